// File: rtl/gather_queue_pkg.sv
// Shared helpers for the gather queue: lane population count used for both
// the per-lane prefix counts in the compactor and the accepted-entry count.
package gather_queue_pkg;

  localparam int unsigned MAX_LANES = 64;

  function automatic int unsigned cnt_bits(input logic [MAX_LANES-1:0] v);
    int unsigned n = 0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gather_queue_gather.sv
// Combinational lane compactor: packs the asserted lanes of a sparse vector
// into ascending dense slots and reports a thermometer of filled slots.
module gather
  import gather_queue_pkg::*;
#(
  parameter int unsigned DATA = 32,
  parameter int unsigned IN   = 4,
  parameter bit          ACT  = 1'b1
) (
  input  logic [IN-1:0][DATA-1:0] in,
  input  logic [IN-1:0]           in_valid,
  output logic [IN-1:0][DATA-1:0] dense,
  output logic [IN-1:0]           dense_valid
);

  logic [IN-1:0] lane_act;
  int unsigned   pre [IN];
  int unsigned   total;

  assign lane_act = ACT ? in_valid : ~in_valid;

  always_comb begin
    // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
    dense       = '0;
    dense_valid = '0;
    total       = cnt_bits(MAX_LANES'(lane_act));
    for (int unsigned j = 0; j < IN; j++) begin
      pre[j] = cnt_bits(MAX_LANES'(lane_act & IN'((1 << j) - 1)));
    end
    // Dense slot k takes the single asserted lane with exactly k asserted lanes below it.
    for (int unsigned k = 0; k < IN; k++) begin
      for (int unsigned j = 0; j < IN; j++) begin
        if (lane_act[j] && (pre[j] == k)) dense[k] = dense[k] | in[j];
      end
      dense_valid[k] = (k < total);
    end
  end

endmodule

// File: rtl/gather_queue.sv
// Circular queue that compacts sparse write lanes and presents the oldest
// entries as a dense, head-aligned read window with variable-count retire.
module gather_queue
  import gather_queue_pkg::*;
#(
  parameter  int unsigned DATA  = 32,
  parameter  int unsigned IN    = 4,
  parameter  int unsigned OUT   = 4,
  parameter  int unsigned DEPTH = 16,
  parameter  bit          ACT   = 1'b1,
  localparam int unsigned PTR   = $clog2(DEPTH),
  localparam int unsigned CNT   = $clog2(DEPTH + 1),
  localparam int unsigned POP   = $clog2(OUT + 1)
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic [IN-1:0][DATA-1:0]  in,
  input  logic [IN-1:0]            in_valid,
  output logic                     in_ready,
  output logic [OUT-1:0][DATA-1:0] out,
  output logic [OUT-1:0]           out_valid,
  input  logic [POP-1:0]           pop,
  output logic [CNT-1:0]           count
);

  localparam logic ENABLE  = logic'(ACT);
  localparam logic DISABLE = logic'(!ACT);

  logic [PTR-1:0]            head_q, head_d, tail_q, tail_d;
  logic [CNT-1:0]            cnt_q, cnt_d, nin, npop;
  logic [DATA-1:0]           mem_q [DEPTH];
  logic [IN-1:0][DATA-1:0]   dense;
  logic [IN-1:0]             dense_valid;
  logic                      push_ok;
  logic [OUT-1:0]            win_valid;
  int unsigned               pop_lim;

  gather #(.DATA(DATA), .IN(IN), .ACT(ACT)) u_gather (
    .in          (in),
    .in_valid    (in_valid),
    .dense       (dense),
    .dense_valid (dense_valid)
  );

  // Admission depends only on registered occupancy, never on this cycle's valid or pop.
  always_comb begin
    push_ok = reset_ && ((DEPTH - 32'(cnt_q)) >= IN);
    nin     = push_ok ? CNT'(cnt_bits(MAX_LANES'(dense_valid))) : '0;
    pop_lim = 32'(pop);
    if (pop_lim > 32'(cnt_q)) pop_lim = 32'(cnt_q);
    if (pop_lim > OUT)        pop_lim = OUT;
    npop    = CNT'(pop_lim);
    cnt_d   = cnt_q + nin - npop;
    head_d  = head_q + PTR'(npop);
    tail_d  = tail_q + PTR'(nin);
  end

  assign in_ready = push_ok ? ENABLE : DISABLE;
  assign count    = cnt_q;

  always_comb begin
    out       = '0;
    win_valid = '0;
    for (int unsigned i = 0; i < OUT; i++) begin
      win_valid[i] = (i < 32'(cnt_q));
      if (win_valid[i]) out[i] = mem_q[head_q + PTR'(i)];
    end
  end

  assign out_valid = ACT ? win_valid : ~win_valid;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // NOTE: storage has no reset; entries are only observable once counted by cnt_q.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < IN; k++) begin
      if (push_ok && dense_valid[k]) mem_q[tail_q + PTR'(k)] <= dense[k];
    end
  end

endmodule

// File: tb/tb_gather_queue.sv
// Directed self-checking bench for gather_queue: compaction, saturating pop,
// full handling, pointer wrap, concurrent push/pop and asynchronous reset.
module tb_gather_queue;

  localparam int DATA  = 32;
  localparam int IN    = 4;
  localparam int OUT   = 4;
  localparam int DEPTH = 16;
  localparam int CNT   = $clog2(DEPTH + 1);
  localparam int POP   = $clog2(OUT + 1);

  logic                     clk = 1'b0;
  logic                     reset_;
  logic [IN-1:0][DATA-1:0]  in;
  logic [IN-1:0]            in_valid;
  logic                     in_ready;
  logic [OUT-1:0][DATA-1:0] out;
  logic [OUT-1:0]           out_valid;
  logic [POP-1:0]           pop;
  logic [CNT-1:0]           count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gather_queue #(.DATA(DATA), .IN(IN), .OUT(OUT), .DEPTH(DEPTH), .ACT(1'b1)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .pop       (pop),
    .count     (count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_win(input string tag, input logic [3:0] ev,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    check({tag, ".valid"}, 64'(out_valid), 64'(ev));
    check({tag, ".out0"},  64'(out[0]),    64'(e0));
    check({tag, ".out1"},  64'(out[1]),    64'(e1));
    check({tag, ".out2"},  64'(out[2]),    64'(e2));
    check({tag, ".out3"},  64'(out[3]),    64'(e3));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3, input logic [2:0] p);
    in_valid = v;
    in[0] = d0; in[1] = d1; in[2] = d2; in[3] = d3;
    pop = p;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_ = 1'b0;
    drive(4'b0000, 0, 0, 0, 0, 0);
    #2;
    check("rst.ready", 64'(in_ready), 64'(1'b0));
    check("rst.count", 64'(count), 64'd0);
    check_win("rst", 4'b0000, 0, 0, 0, 0);
    #10 reset_ = 1'b1;

    // 1: idle after reset
    step();
    check("idle.ready", 64'(in_ready), 64'(1'b1));
    check("idle.count", 64'(count), 64'd0);
    check_win("idle", 4'b0000, 0, 0, 0, 0);

    // 2: sparse compaction, lanes 1 and 3
    drive(4'b1010, 32'hA, 32'hB, 32'hC, 32'hD, 0);
    step();
    drive(4'b0000, 0, 0, 0, 0, 0);
    check("sparse.count", 64'(count), 64'd2);
    check_win("sparse", 4'b0011, 32'hB, 32'hD, 0, 0);

    // 3: saturated pop (head and tail both 2 afterwards)
    pop = 3'd3;
    step();
    pop = 3'd0;
    check("satpop.count", 64'(count), 64'd0);
    check_win("satpop", 4'b0000, 0, 0, 0, 0);

    // 4: fill to full
    for (int n = 0; n < 4; n++) begin
      drive(4'b1111, 32'h100 + 32'(4*n), 32'h101 + 32'(4*n), 32'h102 + 32'(4*n), 32'h103 + 32'(4*n), 0);
      step();
      check("fill.count", 64'(count), 64'(4*(n+1)));
      check("fill.ready", 64'(in_ready), 64'(n < 3));
    end
    check_win("full", 4'b1111, 32'h100, 32'h101, 32'h102, 32'h103);
    drive(4'b1111, 32'hDEAD0, 32'hDEAD1, 32'hDEAD2, 32'hDEAD3, 0);
    step();
    check("overfill.count", 64'(count), 64'd16);
    check("overfill.ready", 64'(in_ready), 64'(1'b0));
    check_win("overfill", 4'b1111, 32'h100, 32'h101, 32'h102, 32'h103);

    // drain, checking FIFO order
    for (int n = 0; n < 4; n++) begin
      drive(4'b0000, 0, 0, 0, 0, 3'd4);
      step();
      check("drain.count", 64'(count), 64'(12 - 4*n));
      if (n < 3)
        check_win("drain", 4'b1111, 32'h104 + 32'(4*n), 32'h105 + 32'(4*n), 32'h106 + 32'(4*n), 32'h107 + 32'(4*n));
      else
        check_win("drained", 4'b0000, 0, 0, 0, 0);
    end

    // 5: move head and tail from 2 to 14, then push a group straddling the wrap
    for (int n = 0; n < 3; n++) begin
      drive(4'b1111, 32'h200, 32'h201, 32'h202, 32'h203, 0);
      step();
    end
    for (int n = 0; n < 3; n++) begin
      drive(4'b0000, 0, 0, 0, 0, 3'd4);
      step();
    end
    check("prewrap.count", 64'(count), 64'd0);
    drive(4'b1111, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 0);
    step();
    check("wrap.count", 64'(count), 64'd4);
    check_win("wrap", 4'b1111, 32'hE0, 32'hE1, 32'hE2, 32'hE3);

    // 6: simultaneous push and pop
    drive(4'b0001, 32'hF0, 32'h0, 32'h0, 32'h0, 0);
    step();
    check("pp.pre.count", 64'(count), 64'd5);
    drive(4'b1110, 32'hBAD, 32'hC1, 32'hC2, 32'hC3, 3'd2);
    step();
    drive(4'b0000, 0, 0, 0, 0, 0);
    check("pp.count", 64'(count), 64'd6);
    check_win("pp", 4'b1111, 32'hE2, 32'hE3, 32'hF0, 32'hC1);

    // mid-cycle asynchronous reset
    #2 reset_ = 1'b0;
    #1;
    check("midrst.count", 64'(count), 64'd0);
    check("midrst.ready", 64'(in_ready), 64'(1'b0));
    check_win("midrst", 4'b0000, 0, 0, 0, 0);
    #3 reset_ = 1'b1;
    step();
    check("post.ready", 64'(in_ready), 64'(1'b1));
    check("post.count", 64'(count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
